decode_ctrl_seq: RTL and testbench
==================================

DECODE_CTRL_SEQ -- requirements
Module: decode_ctrl_seq

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, meaning cycles a multiply/divide occupies the execute unit (legal range 1..15).
REQ-002 SHALL have parameter ALU_OP_W, default 3, meaning width of the ALU-op field.
REQ-003 SHALL have i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have i_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have i_opcode[6:0], i_funct7[6:0] and i_valid (1), inputs, carrying the decoded instruction fields and the qualifier for the instruction in ID.
REQ-006 SHALL have i_stall (1) and i_flush (1), inputs, from the hazard unit.
REQ-007 SHALL have o_ready, output, 1, meaning ID may hand over the next instruction.
REQ-008 SHALL have o_valid, output, 1, meaning the registered control vector is live.
REQ-009 SHALL have registered control outputs, each the width stated: o_result_src[1:0], o_mem_write, o_reg_write, o_jmp, o_branch, o_alu_op[ALU_OP_W-1:0], o_alu_src_opa[1:0], o_alu_src_opb, o_imm_src[2:0], o_md_sel (1), o_md_start (1), o_illegal (1).

Function
REQ-010 SHALL decode the opcodes for R, load, I-operation, JALR, S, JAL, B, LUI and AUIPC into the team's standard control vector, and SHALL register the result so that an accepted instruction appears on the outputs exactly 1 cycle later.
REQ-011 SHALL accept an instruction only when i_valid && o_ready && !i_stall.
REQ-012 SHALL hold every output unchanged while i_stall=1, provided i_flush=0.
REQ-013 SHALL, on i_flush=1, clear o_valid and all control outputs on the next edge, abort any multiply/divide sequence and return to IDLE; i_flush has priority over i_stall and over a new accept in the same cycle.
REQ-014 SHALL, for an unknown opcode, drive all controls to 0, o_valid=1 and o_illegal=1 for 1 cycle; o_illegal SHALL never coincide with o_reg_write=1 or o_mem_write=1.
REQ-015 SHALL implement the FSM states IDLE, MD_BUSY and MD_DONE, with the following behaviour:
- IDLE to MD_BUSY: on accepting an R-type with funct7=0000001.
- MD_BUSY to MD_DONE: when the down-counter reaches 0.
- MD_DONE to IDLE: on the next non-stalled cycle.
REQ-016 SHALL, on entry to MD_BUSY:
- pulse o_md_start for 1 cycle;
- load the counter with MD_LAT-1;
- drive o_ready=0 throughout MD_BUSY.
REQ-017 SHALL, in MD_DONE, present o_valid=1, o_reg_write=1, o_md_sel=1, o_result_src=00 for 1 cycle, then raise o_ready.
REQ-018 SHALL, with MD_LAT=1, go from MD_BUSY to MD_DONE after exactly 1 cycle, so the counter never wraps.
REQ-019 SHALL not decrement the counter while i_stall=1 in MD_BUSY.
REQ-020 SHALL drive o_valid=0 for a cycle in which no instruction was accepted, outside MD_DONE.

Reset
REQ-021 SHALL, when i_rst=1 at a clock edge, enter IDLE, set the counter to 0, set every output to 0 except o_ready=1, and discard any in-flight sequence; reset mid-MD_BUSY produces no MD_DONE.

Configuration
REQ-022 SHALL honour macro RV_M_EXT_EN:
- Defined: the M-extension sequencing of REQ-015 to REQ-019 applies.
- Undefined: MD_BUSY/MD_DONE and the counter are not built, o_md_sel and o_md_start are tied to 0, and funct7=0000001 R-types decode as illegal (REQ-014).

Structure
REQ-023 SHALL take the opcode constants, the funct7 M-encoding, the FSM state encoding and the control-vector field widths from the shared riscv_defines package.
REQ-024 SHALL instantiate the combinational opcode-to-vector decode as sub-module ctrl_decode_table; the sequencing and registering SHALL live in decode_ctrl_seq.

Verification
REQ-025 The bench SHALL cover each of the following scenarios:
- Lw issue: i_opcode=0000011, i_valid=1, issued one cycle after reset → o_valid=1, o_result_src=01, o_reg_write=1, o_alu_src_opb=1, o_imm_src=000 on the next cycle.
- Multiply latency: MD_LAT=4, R-type with funct7=0000001 → o_md_start pulses, o_ready=0 for 4 cycles, then MD_DONE with o_md_sel=1 and o_reg_write=1; o_ready=1 after that.
- Stall during multiply: i_stall=1 for 2 cycles inside MD_BUSY → MD_DONE is delayed by exactly 2 cycles, and outputs stay held.
- Flush priority: i_flush=1 together with i_stall=1 and a valid sw → outputs all 0, o_valid=0, state IDLE next cycle.
- Illegal opcode: i_opcode=1111111 → o_illegal=1 for 1 cycle, o_reg_write=0, o_mem_write=0.
- Mid-sequence reset and macro off: i_rst asserted 2 cycles into MD_BUSY gives no MD_DONE and o_ready=1; with RV_M_EXT_EN undefined, a mul instruction gives o_illegal=1.

Source files
------------

// File: rtl/riscv_defines.sv
// riscv_defines: shared opcodes, M-encoding funct7, FSM state encoding and control-vector layout
package riscv_defines;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_M     = 7'b0000001;
  localparam int RES_SRC_W = 2;
  localparam int OPA_W     = 2;
  localparam int IMM_SRC_W = 3;
  localparam int CNT_W     = 4;
  localparam int ALUOP_ADD   = 0;
  localparam int ALUOP_SUB   = 1;
  localparam int ALUOP_FUNCT = 2;
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MD_BUSY = 2'd1, S_MD_DONE = 2'd2} state_t;
  typedef struct packed {
    logic [RES_SRC_W-1:0] result_src;
    logic                 mem_write;
    logic                 reg_write;
    logic                 jmp;
    logic                 branch;
    logic [OPA_W-1:0]     alu_src_opa;
    logic                 alu_src_opb;
    logic [IMM_SRC_W-1:0] imm_src;
    logic                 illegal;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode_table.sv
// ctrl_decode_table: combinational opcode/funct7 -> control vector (ports: i_opcode, i_funct7 in; o_ctrl, o_alu_op, o_is_md out); RV_M_EXT_EN makes M-encoded R-types legal
module ctrl_decode_table
  import riscv_defines::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [6:0]          i_opcode,
  input  logic [6:0]          i_funct7,
  output ctrl_t               o_ctrl,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_is_md
);
  logic w_m;
  assign w_m = i_opcode == OP_R && i_funct7 == F7_M;
  always_comb begin
    o_ctrl = '0;
    o_alu_op = ALU_OP_W'(ALUOP_ADD);
    o_is_md = 1'b0;
    case (i_opcode)
      OP_R:     begin o_ctrl.reg_write = 1'b1; o_alu_op = ALU_OP_W'(ALUOP_FUNCT); end
      OP_LOAD:  begin o_ctrl.reg_write = 1'b1; o_ctrl.result_src = RES_MEM; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_I; end
      OP_IMM:   begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_I; o_alu_op = ALU_OP_W'(ALUOP_FUNCT); end
      OP_JALR:  begin o_ctrl.reg_write = 1'b1; o_ctrl.result_src = RES_PC4; o_ctrl.jmp = 1'b1; o_ctrl.alu_src_opa = OPA_RS1; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_I; end
      OP_S:     begin o_ctrl.mem_write = 1'b1; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_S; end
      OP_JAL:   begin o_ctrl.reg_write = 1'b1; o_ctrl.result_src = RES_PC4; o_ctrl.jmp = 1'b1; o_ctrl.alu_src_opa = OPA_PC; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_J; end
      OP_B:     begin o_ctrl.branch = 1'b1; o_ctrl.imm_src = IMM_B; o_alu_op = ALU_OP_W'(ALUOP_SUB); end
      OP_LUI:   begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_src_opa = OPA_ZERO; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_U; end
      OP_AUIPC: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_src_opa = OPA_PC; o_ctrl.alu_src_opb = 1'b1; o_ctrl.imm_src = IMM_U; end
      default:  o_ctrl.illegal = 1'b1;
    endcase
    if (w_m) begin
      o_ctrl = '0;
      o_alu_op = '0;
`ifdef RV_M_EXT_EN
      o_is_md = 1'b1;
`else
      o_ctrl.illegal = 1'b1;
`endif
    end
  end
endmodule

// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq: registers the decoded control vector and sequences multiply/divide (i_clk/i_rst, i_opcode/i_funct7/i_valid, i_stall/i_flush in; o_ready, o_valid, control vector out; RV_M_EXT_EN enables MD FSM)
module decode_ctrl_seq
  import riscv_defines::*;
#(
  parameter int MD_LAT   = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_opcode,
  input  logic [6:0]           i_funct7,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [1:0]           o_result_src,
  output logic                 o_mem_write,
  output logic                 o_reg_write,
  output logic                 o_jmp,
  output logic                 o_branch,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic [1:0]           o_alu_src_opa,
  output logic                 o_alu_src_opb,
  output logic [2:0]           o_imm_src,
  output logic                 o_md_sel,
  output logic                 o_md_start,
  output logic                 o_illegal
);
  if (MD_LAT < 1 || MD_LAT > 15) begin : g_md_lat_chk
    $error("MD_LAT must be in 1..15");
  end
  ctrl_t               w_dec, w_ctrl_nxt;
  logic [ALU_OP_W-1:0] w_dec_alu_op;
  logic                w_dec_md, w_accept, w_issue, w_md_start_nxt, w_md_sel_nxt;
  ctrl_decode_table #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .i_opcode(i_opcode),
    .i_funct7(i_funct7),
    .o_ctrl  (w_dec),
    .o_alu_op(w_dec_alu_op),
    .o_is_md (w_dec_md)
  );
  assign w_accept = i_valid && o_ready && !i_stall;
  assign w_issue  = w_accept && !w_dec_md;
`ifdef RV_M_EXT_EN
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_busy_run;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  assign w_busy_run     = r_state == S_MD_BUSY && !i_stall;
  assign w_md_start_nxt = w_accept && w_dec_md;
  assign w_md_sel_nxt   = w_busy_run && r_cnt == '0;
  always_comb begin
    w_state_nxt = w_md_start_nxt ? S_MD_BUSY :
                  w_md_sel_nxt ? S_MD_DONE :
                  (r_state == S_MD_DONE && !i_stall) ? S_IDLE : r_state;
    w_cnt_nxt = w_md_start_nxt ? CNT_W'(MD_LAT - 1) :
                (w_busy_run && r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
  end
  assign o_ready = r_state == S_IDLE;
`else
  assign w_md_start_nxt = 1'b0;
  assign w_md_sel_nxt   = 1'b0;
  assign o_ready        = 1'b1;
`endif
  // MD_DONE write-back: only reg_write set, result_src stays 00
  always_comb begin
    w_ctrl_nxt = '0;
    w_ctrl_nxt.reg_write = w_md_sel_nxt;
    if (w_issue) w_ctrl_nxt = w_dec;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_valid <= 1'b0;
      o_alu_op <= '0;
      o_md_sel <= 1'b0;
      o_md_start <= 1'b0;
      {o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch, o_alu_src_opa, o_alu_src_opb, o_imm_src, o_illegal} <= '0;
    end else if (!i_stall) begin
      o_valid <= w_issue || w_md_sel_nxt;
      o_alu_op <= w_issue ? w_dec_alu_op : '0;
      o_md_sel <= w_md_sel_nxt;
      o_md_start <= w_md_start_nxt;
      {o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch, o_alu_src_opa, o_alu_src_opb, o_imm_src, o_illegal} <= w_ctrl_nxt;
    end
  end
endmodule

// File: tb/tb_decode_ctrl_seq.sv
// tb_decode_ctrl_seq: directed scoreboard bench for decode_ctrl_seq (M-extension steps under RV_M_EXT_EN)
module tb_decode_ctrl_seq;
  logic       i_clk, i_rst, i_valid, i_stall, i_flush;
  logic [6:0] i_opcode, i_funct7;
  logic       o_ready, o_valid, o_mem_write, o_reg_write, o_jmp, o_branch;
  logic       o_alu_src_opb, o_md_sel, o_md_start, o_illegal;
  logic [1:0] o_result_src, o_alu_src_opa;
  logic [2:0] o_alu_op, o_imm_src;
  logic [19:0] w_obs;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [19:0] e;
    string       tag;
  } exp_t;
  exp_t sb[$];
  decode_ctrl_seq #(.MD_LAT(4), .ALU_OP_W(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct7(i_funct7),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .o_ready(o_ready), .o_valid(o_valid), .o_result_src(o_result_src),
    .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_jmp(o_jmp),
    .o_branch(o_branch), .o_alu_op(o_alu_op), .o_alu_src_opa(o_alu_src_opa),
    .o_alu_src_opb(o_alu_src_opb), .o_imm_src(o_imm_src), .o_md_sel(o_md_sel),
    .o_md_start(o_md_start), .o_illegal(o_illegal)
  );
  assign w_obs = {o_ready, o_valid, o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch,
                  o_alu_op, o_alu_src_opa, o_alu_src_opb, o_imm_src, o_md_sel, o_md_start, o_illegal};
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [19:0] mk(logic rdy, logic vld, logic [1:0] res, logic mw, logic rw,
                                     logic j, logic b, logic [2:0] alu, logic [1:0] opa,
                                     logic opb, logic [2:0] imm, logic sel, logic st, logic ill);
    return {rdy, vld, res, mw, rw, j, b, alu, opa, opb, imm, sel, st, ill};
  endfunction
  task automatic cyc(input logic [6:0] op, input logic [6:0] f7, input logic v, input logic st,
                     input logic fl, input logic rs, input logic [19:0] e, input string tag);
    exp_t x;
    i_opcode = op;
    i_funct7 = f7;
    i_valid = v;
    i_stall = st;
    i_flush = fl;
    i_rst = rs;
    sb.push_back('{e: e, tag: tag});
    @(posedge i_clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (w_obs === x.e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", x.tag, w_obs, x.e);
    end
  endtask
  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, SW = 7'b0100011, M7 = 7'b0000001;
  logic [19:0] e_idle, e_busy, e_start, e_done, e_ill, e_load, e_s;
  logic [6:0]  t_op[10], t_f7[10];
  logic [19:0] t_e[10];
  string       t_n[10];
  initial begin
    e_idle  = mk(1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 0, 3'b000, 0, 0, 0);
    e_busy  = mk(0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 0, 3'b000, 0, 0, 0);
    e_start = mk(0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 0, 3'b000, 0, 1, 0);
    e_done  = mk(0, 1, 2'b00, 0, 1, 0, 0, 3'b000, 2'b00, 0, 3'b000, 1, 0, 0);
    e_ill   = mk(1, 1, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 0, 3'b000, 0, 0, 1);
    e_load  = mk(1, 1, 2'b01, 0, 1, 0, 0, 3'b000, 2'b00, 1, 3'b000, 0, 0, 0);
    e_s     = mk(1, 1, 2'b00, 1, 0, 0, 0, 3'b000, 2'b00, 1, 3'b001, 0, 0, 0);
    t_op = '{R, R, 7'b0010011, 7'b1100111, SW, 7'b1101111, 7'b1100011, 7'b0110111, 7'b0010111, LD};
    t_f7 = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    t_n  = '{"r_add", "r_sub", "i_op", "jalr", "sw", "jal", "beq", "lui", "auipc", "lw_b2b"};
    t_e[0] = mk(1, 1, 2'b00, 0, 1, 0, 0, 3'b010, 2'b00, 0, 3'b000, 0, 0, 0);
    t_e[1] = t_e[0];
    t_e[2] = mk(1, 1, 2'b00, 0, 1, 0, 0, 3'b010, 2'b00, 1, 3'b000, 0, 0, 0);
    t_e[3] = mk(1, 1, 2'b10, 0, 1, 1, 0, 3'b000, 2'b00, 1, 3'b000, 0, 0, 0);
    t_e[4] = e_s;
    t_e[5] = mk(1, 1, 2'b10, 0, 1, 1, 0, 3'b000, 2'b01, 1, 3'b011, 0, 0, 0);
    t_e[6] = mk(1, 1, 2'b00, 0, 0, 0, 1, 3'b001, 2'b00, 0, 3'b010, 0, 0, 0);
    t_e[7] = mk(1, 1, 2'b00, 0, 1, 0, 0, 3'b000, 2'b10, 1, 3'b100, 0, 0, 0);
    t_e[8] = mk(1, 1, 2'b00, 0, 1, 0, 0, 3'b000, 2'b01, 1, 3'b100, 0, 0, 0);
    t_e[9] = e_load;
    cyc(7'h00, 7'h00, 0, 0, 0, 1, e_idle, "reset0");
    cyc(7'h00, 7'h00, 0, 0, 0, 1, e_idle, "reset1");
    cyc(LD, 7'h00, 1, 0, 0, 0, e_load, "lw_issue");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "idle_after_lw");
    for (int i = 0; i < 10; i++) cyc(t_op[i], t_f7[i], 1, 0, 0, 0, t_e[i], t_n[i]);
    cyc(SW, 7'h00, 1, 0, 0, 0, e_s, "sw_before_stall");
    cyc(LD, 7'h00, 1, 1, 0, 0, e_s, "stall_hold0");
    cyc(LD, 7'h00, 1, 1, 0, 0, e_s, "stall_hold1");
    cyc(LD, 7'h00, 1, 0, 0, 0, e_load, "after_stall");
    cyc(7'h7f, 7'h00, 1, 0, 0, 0, e_ill, "illegal");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "illegal_1cyc");
    cyc(7'h7f, 7'h00, 0, 0, 0, 0, e_idle, "invalid_no_issue");
    cyc(LD, 7'h00, 1, 0, 0, 0, e_load, "lw_pre_flush");
    cyc(SW, 7'h00, 1, 1, 1, 0, e_idle, "flush_prio_stall");
    cyc(SW, 7'h00, 1, 0, 1, 0, e_idle, "flush_prio_accept");
    cyc(SW, 7'h00, 1, 0, 0, 0, e_s, "after_flush");
    cyc(LD, 7'h00, 1, 0, 0, 1, e_idle, "rst_prio");
`ifdef RV_M_EXT_EN
    cyc(R, M7, 1, 0, 0, 0, e_start, "mul_start");
    cyc(LD, 7'h00, 1, 0, 0, 0, e_busy, "mul_busy1");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "mul_busy2");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "mul_busy3");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_done, "mul_done");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "mul_ready");
    cyc(R, M7, 1, 0, 0, 0, e_start, "stl_start");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "stl_busy1");
    cyc(7'h00, 7'h00, 0, 1, 0, 0, e_busy, "stl_hold0");
    cyc(7'h00, 7'h00, 0, 1, 0, 0, e_busy, "stl_hold1");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "stl_busy2");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "stl_busy3");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_done, "stl_done");
    cyc(LD, 7'h00, 1, 1, 0, 0, e_done, "done_stall_hold");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "stl_ready");
    cyc(R, M7, 1, 0, 0, 0, e_start, "rst_mul_start");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "rst_mul_busy1");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_busy, "rst_mul_busy2");
    cyc(7'h00, 7'h00, 0, 0, 0, 1, e_idle, "mid_rst");
    for (int i = 0; i < 4; i++) cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "no_done_after_rst");
    cyc(R, M7, 1, 0, 0, 0, e_start, "fl_mul_start");
    cyc(7'h00, 7'h00, 0, 1, 1, 0, e_idle, "mid_flush");
    for (int i = 0; i < 4; i++) cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "no_done_after_flush");
`else
    cyc(R, M7, 1, 0, 0, 0, e_ill, "mul_illegal");
    cyc(7'h00, 7'h00, 0, 0, 0, 0, e_idle, "mul_illegal_1cyc");
    cyc(R, M7, 1, 1, 0, 0, e_idle, "mul_stalled_no_accept");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
